// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port memory with a fixed
// number of wait cycles. Optional round-robin tie-break: define MEM_ARB_RR_EN.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic        d_ack,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic        gnt_data_q, gnt_data_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pick_data;

`ifdef MEM_ARB_RR_EN
    // Remembers who won last; resets to data so the very first tie goes to fetch.
    logic last_data_q, last_data_d;
    assign pick_data = d_req && !(if_req && last_data_q);
`else
    assign pick_data = d_req;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_data_d = gnt_data_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
`ifdef MEM_ARB_RR_EN
        last_data_d = last_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    state_d    = ACCESS;
                    gnt_data_d = pick_data;
                    wait_d     = WAIT_INIT;
`ifdef MEM_ARB_RR_EN
                    last_data_d = pick_data;
`endif
                    if (pick_data) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        be_d    = d_be;
                        we_d    = d_we;
                    end else begin
                        addr_d  = if_addr;
                        wdata_d = '0;
                        be_d    = 4'b1111;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d = RESP;
                    // Stores leave the shared read-data register untouched.
                    if (!we_q) rdata_d = mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            gnt_data_q <= 1'b1;
            wait_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            rdata_q    <= '0;
`ifdef MEM_ARB_RR_EN
            last_data_q <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            gnt_data_q <= gnt_data_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            rdata_q    <= rdata_d;
`ifdef MEM_ARB_RR_EN
            last_data_q <= last_data_d;
`endif
        end
    end

    // All outputs decode from registers only, so an async reset clears them at once.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign if_ack    = (state_q == RESP) && !gnt_data_q;
    assign d_ack     = (state_q == RESP) && gnt_data_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: W=1 main instance plus W=0 and W=15 instances
// sharing the same stimulus for the latency tests.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;

    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        if_ack0, d_ack0, mem_en0, mem_we0, busy0;
    logic [31:0] rdata0, mem_addr0, mem_wdata0;
    logic [3:0]  mem_be0;

    logic        if_ack15, d_ack15, mem_en15, mem_we15, busy15;
    logic [31:0] rdata15, mem_addr15, mem_wdata15;
    logic [3:0]  mem_be15;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rstn(rstn), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .busy(busy));

    mem_arbiter #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack0),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack0), .rdata(rdata0), .mem_en(mem_en0), .mem_we(mem_we0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_be(mem_be0),
        .mem_rdata(mem_rdata), .busy(busy0));

    mem_arbiter #(.WAIT_CYCLES(15)) dut15 (
        .clk(clk), .rstn(rstn), .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack15),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ack(d_ack15), .rdata(rdata15), .mem_en(mem_en15), .mem_we(mem_we15),
        .mem_addr(mem_addr15), .mem_wdata(mem_wdata15), .mem_be(mem_be15),
        .mem_rdata(mem_rdata), .busy(busy15));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        if_req = 0; d_req = 0;
        rstn = 0;
        tick(); tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_reset;
        rstn = 0; if_req = 0; d_req = 0; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        #3;
        checks++;
        if ({if_ack, d_ack, mem_en, mem_we, busy} !== 5'b0) begin
            errors++; $display("FAIL reset_ctl got=%b want=00000", {if_ack, d_ack, mem_en, mem_we, busy});
        end
        checks++;
        if ({rdata, mem_addr, mem_wdata, mem_be} !== 100'h0) begin
            errors++; $display("FAIL reset_data got rdata=%h addr=%h wdata=%h be=%b want 0", rdata, mem_addr, mem_wdata, mem_be);
        end
        tick(); tick();
        rstn = 1;
        tick();
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h0000_3000; mem_rdata = 32'h8C08_0004;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1 || c == 2) begin
                checks++;
                if ({mem_en, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h0000_3000}) begin
                    errors++; $display("FAIL fetch_access c=%0d got en=%b we=%b be=%b addr=%h want 1 0 1111 00003000", c, mem_en, mem_we, mem_be, mem_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if ({if_ack, d_ack, mem_en, rdata} !== {3'b100, 32'h8C08_0004}) begin
                    errors++; $display("FAIL fetch_ack got if_ack=%b d_ack=%b en=%b rdata=%h want 1 0 0 8c080004", if_ack, d_ack, mem_en, rdata);
                end
                if_req = 0;
            end
            if (c == 4) begin
                checks++;
                if ({busy, if_ack} !== 2'b00) begin
                    errors++; $display("FAIL fetch_idle got busy=%b if_ack=%b want 0 0", busy, if_ack);
                end
            end
        end
    endtask

    task automatic test_store(input logic [3:0] be, input string nm);
        d_req = 1; d_we = 1; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF; d_be = be;
        mem_rdata = 32'h1111_1111;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1 || c == 2) begin
                checks++;
                if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b11, be, 32'h10, 32'hDEAD_BEEF}) begin
                    errors++; $display("FAIL %s_access c=%0d got en=%b we=%b be=%b addr=%h wdata=%h", nm, c, mem_en, mem_we, mem_be, mem_addr, mem_wdata);
                end
            end
            if (c == 3) begin
                checks++;
                if ({d_ack, if_ack, rdata} !== {2'b10, 32'h8C08_0004}) begin
                    errors++; $display("FAIL %s_ack got d_ack=%b if_ack=%b rdata=%h want 1 0 8c080004", nm, d_ack, if_ack, rdata);
                end
                d_req = 0;
            end
            if (c == 4) begin
                checks++;
                if ({d_ack, busy} !== 2'b00) begin
                    errors++; $display("FAIL %s_once got d_ack=%b busy=%b want 0 0", nm, d_ack, busy);
                end
            end
        end
        d_we = 0;
    endtask

    task automatic test_priority;
        logic [3:0] seq;
        logic [3:0] want;
        int n = 0;
        int last_c = 0;
        do_reset();
        seq = '0;
`ifdef MEM_ARB_RR_EN
        want = 4'b1010;
`else
        want = 4'b1111;
`endif
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            tick();
            if (if_ack && d_ack) begin
                checks++; errors++;
                $display("FAIL prio_both_ack c=%0d got both acks high want one", c);
            end
            if (if_ack || d_ack) begin
                seq[n] = d_ack;
                n++;
                last_c = c;
            end
        end
        if_req = 0; d_req = 0;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL prio_count got=%0d want=4 grants", n);
        end
        checks++;
        if (seq !== want) begin
            errors++; $display("FAIL prio_order got=%b want=%b (bit0 first, 1=data)", seq, want);
        end
        checks++;
        if (last_c != 15) begin
            errors++; $display("FAIL prio_timing got 4th ack cycle=%0d want=15", last_c);
        end
    endtask

    task automatic test_back_to_back;
        int a0[2];
        int a15[2];
        int n0 = 0;
        int n15 = 0;
        do_reset();
        a0[0] = 0; a0[1] = 0; a15[0] = 0; a15[1] = 0;
        d_req = 1; d_we = 0; d_addr = 32'h20; mem_rdata = 32'h5A5A_0000;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (d_ack0 && n0 < 2) begin a0[n0] = c; n0++; end
            if (d_ack15 && n15 < 2) begin a15[n15] = c; n15++; end
            if (c == 3) begin
                checks++;
                if (busy0 !== 1'b0) begin
                    errors++; $display("FAIL b2b_w0_idle got busy=%b want 0 at cycle 3", busy0);
                end
            end
            if (c == 18) begin
                checks++;
                if (busy15 !== 1'b0) begin
                    errors++; $display("FAIL b2b_w15_idle got busy=%b want 0 at cycle 18", busy15);
                end
            end
        end
        d_req = 0;
        checks++;
        if (a0[0] != 2 || a0[1] != 5) begin
            errors++; $display("FAIL b2b_w0_lat got %0d,%0d want 2,5", a0[0], a0[1]);
        end
        checks++;
        if (a15[0] != 17 || a15[1] != 35) begin
            errors++; $display("FAIL b2b_w15_lat got %0d,%0d want 17,35", a15[0], a15[1]);
        end
        checks++;
        if (rdata0 !== 32'h5A5A_0000) begin
            errors++; $display("FAIL b2b_w0_rdata got=%h want=5a5a0000", rdata0);
        end
    endtask

    task automatic test_reset_abort;
        do_reset();
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hCAFE_F00D; d_be = 4'hF;
        tick();
        checks++;
        if ({mem_en, mem_we} !== 2'b11) begin
            errors++; $display("FAIL abort_pre got en=%b we=%b want 1 1", mem_en, mem_we);
        end
        tick();
        #2 rstn = 0;
        #1;
        checks++;
        if ({mem_en, mem_we, busy, d_ack} !== 4'b0) begin
            errors++; $display("FAIL abort_async got en=%b we=%b busy=%b d_ack=%b want 0000", mem_en, mem_we, busy, d_ack);
        end
        d_req = 0;
        tick(); tick();
        rstn = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (d_ack !== 1'b0) begin
                checks++; errors++;
                $display("FAIL abort_no_ack got d_ack=%b want 0", d_ack);
            end
        end
        d_req = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if ({mem_en, mem_we, mem_addr} !== {2'b11, 32'h44}) begin
                    errors++; $display("FAIL reissue_access got en=%b we=%b addr=%h want 1 1 00000044", mem_en, mem_we, mem_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if (d_ack !== 1'b1) begin
                    errors++; $display("FAIL reissue_ack got=%b want=1", d_ack);
                end
                d_req = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store(4'b0011, "store");
        test_store(4'b0000, "store_be0");
        test_priority();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 1, meaning extra memory wait cycles per access (legal 0..15).
REQ-002 The block SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port if_req  input  1  instruction-fetch request, level, held until if_ack.
REQ-005 The block SHALL have port if_addr  input  32  fetch byte address.
REQ-006 The block SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 The block SHALL have port d_req  input  1  load/store request, level, held until d_ack.
REQ-008 The block SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-009 The block SHALL have ports d_addr  input  32, d_wdata  input  32 and d_be  input  4, carrying data address, store data and byte enables.
REQ-010 The block SHALL have port d_ack  output  1  one-cycle load/store completion pulse.
REQ-011 The block SHALL have port rdata  output  32  read data, shared by both requesters, valid with the ack.
REQ-012 The block SHALL have ports mem_en  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32 and mem_be  output  4, forming the single-port memory command.
REQ-013 The block SHALL have port mem_rdata  input  32  memory read data, valid in the last ACCESS cycle.
REQ-014 The block SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-015 The block SHALL implement states IDLE, ACCESS and RESP.
- IDLE: if any request is high -> ACCESS; else stay.
- ACCESS: stay while the wait counter is nonzero, decrementing it each cycle; at zero -> RESP.
- RESP: -> IDLE unconditionally.
REQ-016 On leaving IDLE, the block SHALL register the grant, the winner's address, wdata, be and we, and load the wait counter with WAIT_CYCLES.
REQ-017 In ACCESS, mem_en SHALL be 1 and the mem_* outputs SHALL be driven from the registered command.
REQ-018 A fetch grant SHALL drive mem_we = 0 and mem_be = 4'b1111; in all states other than ACCESS, mem_en and mem_we SHALL be 0.
REQ-019 On the final ACCESS edge, the block SHALL capture mem_rdata into rdata; for stores, rdata SHALL hold its previous value.
REQ-020 In RESP, exactly one of if_ack/d_ack SHALL be 1, selected by the grant, for exactly one cycle.
REQ-021 Latency: for a request sampled in IDLE at cycle N, the ack SHALL be high in cycle N+2+WAIT_CYCLES.
REQ-022 Requests arriving during ACCESS or RESP SHALL be ignored until the next IDLE; requests are never dropped and never cancelled.
REQ-023 When if_req and d_req are both high in IDLE, the block SHALL grant d_req (fixed priority, unless REQ-028 applies).
REQ-024 The block SHALL have a minimum of one IDLE cycle between consecutive accesses.
REQ-025 A store with d_be = 0 SHALL still perform a full ACCESS/RESP sequence with mem_we = 1 and mem_be = 0.

Reset
REQ-026 rstn low SHALL immediately force state to IDLE, the wait counter to 0, the grant to data, rdata to 0 and mem_addr/mem_wdata/mem_be to 0.
REQ-027 While rstn is low, all acks, mem_en, mem_we and busy SHALL be 0; a reset during ACCESS SHALL abort the access with no ack ever issued for it.

Configuration
REQ-028 When macro MEM_ARB_RR_EN is defined, simultaneous requests SHALL be granted to the requester not granted last time, with the last-grant register reset to data so the first tie goes to fetch; when undefined, fixed data priority (REQ-023) SHALL apply and no last-grant register SHALL exist.

Verification
REQ-029 WAIT_CYCLES=1, if_req with if_addr=0x00003000 sampled at cycle 0, mem_rdata=0x8C080004 -> mem_en high in cycles 1-2, if_ack and rdata=0x8C080004 in cycle 3, busy low in cycle 4.
REQ-030 Store d_addr=0x10, d_wdata=0xDEADBEEF, d_be=4'b0011 -> mem_we=1, mem_be=0011 throughout ACCESS, d_ack once, rdata unchanged.
REQ-031 if_req and d_req held high together for 4 grants -> without MEM_ARB_RR_EN: D,D,D,D (if_req stays pending); with it: I,D,I,D.
REQ-032 WAIT_CYCLES=0 and WAIT_CYCLES=15 with back-to-back loads -> ack at N+2 and N+17 respectively, one IDLE cycle between accesses.
REQ-033 rstn pulsed low in the 2nd ACCESS cycle of a store -> mem_en/mem_we drop asynchronously, no d_ack, and a re-issued store completes normally.
